tlb_access_arbiter_sv32: RTL and testbench
==========================================

Name: tlb_access_arbiter_sv32

Overview:
- Sequences the single-ported cva6_tlb_sv32 among three sources:
  - flush requests (sfence.vma),
  - one PTW update source,
  - NUM_CLIENTS lookup clients (e.g. fetch, load/store).
- Owns every TLB input port. Enforces flush > update > lookup priority, with round-robin among lookup clients.
- Registers lookup results so each response returns to its client one cycle after grant.

Parameters:
- NUM_CLIENTS, 2, number of lookup requesters (1..4).
- ASID_WIDTH, 1, ASID width; must match the TLB.
- STARVE_LIMIT, 4, consecutive update-won cycles with a lookup pending before updates are held off for one cycle.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- flush_req_i  in  1  flush request; level, held until ack
- flush_asid_i  in  ASID_WIDTH  ASID to flush
- flush_vaddr_i  in  32  vaddr to flush
- flush_ack_o  out  1  one-cycle pulse, flush issued
- upd_valid_i  in  1  PTW update valid
- upd_ready_o  out  1  update accepted this cycle
- upd_vpn_i  in  20  update VPN
- upd_asid_i  in  ASID_WIDTH  update ASID
- upd_is_4M_i  in  1  megapage flag
- upd_content_i  in  32  PTE content
- lu_req_i  in  NUM_CLIENTS  lookup requests
- lu_vaddr_i  in  NUM_CLIENTS*32  per-client vaddr, client k at [32k+31:32k]
- lu_asid_i  in  NUM_CLIENTS*ASID_WIDTH  per-client ASID
- lu_gnt_o  out  NUM_CLIENTS  one-hot grant
- rsp_valid_o  out  NUM_CLIENTS  one-hot response valid
- rsp_hit_o  out  1  registered hit
- rsp_is_4M_o  out  1  registered megapage flag
- rsp_content_o  out  32  registered PTE content
- tlb_flush_o  out  1  to TLB flush_i
- tlb_flush_asid_o  out  ASID_WIDTH  to asid_to_be_flushed_i
- tlb_flush_vaddr_o  out  32  to vaddr_to_be_flushed_i
- tlb_update_o  out  63  to update_i
- tlb_lu_access_o  out  1  to lu_access_i
- tlb_lu_asid_o  out  ASID_WIDTH  to lu_asid_i
- tlb_lu_vaddr_o  out  32  to lu_vaddr_i
- tlb_lu_hit_i  in  1  from lu_hit_o
- tlb_lu_is_4M_i  in  1  from lu_is_4M_o
- tlb_lu_content_i  in  32  from lu_content_o

Behaviour:
- Clock and reset: one clock (clk_i); rst_ni is synchronous and active-low.
- FSM states:
  - IDLE
  - FLUSH: drives tlb_flush_o=1, flush_ack_o=1 for exactly one cycle.
  - QUIESCE: one cycle with no grants, so no lookup observes stale tags after a flush.
- FSM transitions:
  - IDLE -> FLUSH when flush_req_i=1.
  - FLUSH -> QUIESCE.
  - QUIESCE -> IDLE. If flush_req_i is still 1 in QUIESCE, the next IDLE cycle goes straight back to FLUSH (new flush).
- Flush data: tlb_flush_asid_o and tlb_flush_vaddr_o follow the flush_* inputs in FLUSH, else 0.
- Update acceptance:
  - In IDLE with flush_req_i=0 and upd_valid_i=1: upd_ready_o=1 unless the starvation hold is active.
  - Same-cycle drive of tlb_update_o = {1, upd_is_4M_i, upd_vpn_i, zero-extended upd_asid_i to 9 bits, upd_content_i}.
  - tlb_update_o = 0 otherwise.
- Lookup grant: IDLE, no flush, no accepted update, at least one lu_req_i.
  - Round-robin pointer rr_q (reset 0). Grant the first requester at or after rr_q; rr_q <= grantee+1 mod NUM_CLIENTS.
  - Combinationally drive tlb_lu_access_o=1 plus the grantee's vaddr/asid; otherwise these are 0.
- Response: at posedge after grant, capture tlb_lu_* into rsp_* and set rsp_valid_o to the grantee's bit for one cycle.
  - rsp_* hold their last value when rsp_valid_o=0.
  - Back-to-back grants yield back-to-back responses.
- Starvation counter (saturating):
  - Increments when an update is accepted while any lu_req_i=1.
  - Clears on any lookup grant or when no lookup is pending.
  - At STARVE_LIMIT: upd_ready_o=0 for one cycle, a lookup is granted, and the counter clears.
- Simultaneous events: flush beats update and lookup. An update arriving during FLUSH/QUIESCE waits with upd_ready_o=0.
- Reset (also mid-operation):
  - state=IDLE, rr_q=0, starve counter=0.
  - All outputs 0, rsp_* = 0.
  - A response pending from a grant in the reset cycle is dropped.

Optional Feature:
- Macro TLB_ARB_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_hit_cnt_o[31:0] and perf_miss_cnt_o[31:0], incremented on each rsp_valid_o with rsp_hit_o=1 / 0 respectively.
  - Counters saturate at 0xFFFFFFFF and reset to 0.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset held 2 cycles, then released -> all outputs 0; first lu_req_i=2'b11 grants client 0 (lu_gnt_o=2'b01), next cycle grants client 1.
- Update vpn=0x12345, asid=1, content=0xDEADBEEF, is_4M=0 -> same cycle tlb_update_o=63'h4_2468_A01_DEADBEEF equivalent {1,0,0x12345,9'd1,0xDEADBEEF}, upd_ready_o=1; then client 0 looks up vaddr 0x12345000 asid 1 -> rsp_valid_o=2'b01 one cycle after grant, rsp_hit_o=1, rsp_content_o=0xDEADBEEF.
- flush_req_i with flush_vaddr_i=0, flush_asid_i=0 while lu_req_i=2'b01 and upd_valid_i=1 -> tlb_flush_o=1 and flush_ack_o=1 for one cycle, no grant or update in FLUSH or QUIESCE; the update is accepted in the following IDLE cycle; a re-lookup of 0x12345000 then returns rsp_hit_o=0.
- upd_valid_i held high 10 cycles with lu_req_i=2'b10 -> after 4 accepted updates upd_ready_o=0 for one cycle, lu_gnt_o=2'b10, then updates resume.
- Assert rst_ni=0 in the cycle of a grant -> no rsp_valid_o next cycle, rsp_content_o=0, rr_q back to 0.
- With TLB_ARB_PERF_CNT_EN: 3 hits and 2 misses -> perf_hit_cnt_o=3, perf_miss_cnt_o=2.

Source files
------------

// File: rtl/tlb_access_arbiter_sv32.sv
// rtl/tlb_access_arbiter_sv32.sv - flush > update > round-robin lookup sequencer for the single-ported sv32 TLB
// Optional hit/miss performance counters are enabled with `define TLB_ARB_PERF_CNT_EN.
module tlb_access_arbiter_sv32 #(
    parameter int NUM_CLIENTS  = 2,
    parameter int ASID_WIDTH   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              flush_req_i,
    input  logic [ASID_WIDTH-1:0]             flush_asid_i,
    input  logic [31:0]                       flush_vaddr_i,
    output logic                              flush_ack_o,
    input  logic                              upd_valid_i,
    output logic                              upd_ready_o,
    input  logic [19:0]                       upd_vpn_i,
    input  logic [ASID_WIDTH-1:0]             upd_asid_i,
    input  logic                              upd_is_4M_i,
    input  logic [31:0]                       upd_content_i,
    input  logic [NUM_CLIENTS-1:0]            lu_req_i,
    input  logic [NUM_CLIENTS*32-1:0]         lu_vaddr_i,
    input  logic [NUM_CLIENTS*ASID_WIDTH-1:0] lu_asid_i,
    output logic [NUM_CLIENTS-1:0]            lu_gnt_o,
    output logic [NUM_CLIENTS-1:0]            rsp_valid_o,
    output logic                              rsp_hit_o,
    output logic                              rsp_is_4M_o,
    output logic [31:0]                       rsp_content_o,
    output logic                              tlb_flush_o,
    output logic [ASID_WIDTH-1:0]             tlb_flush_asid_o,
    output logic [31:0]                       tlb_flush_vaddr_o,
    output logic [62:0]                       tlb_update_o,
    output logic                              tlb_lu_access_o,
    output logic [ASID_WIDTH-1:0]             tlb_lu_asid_o,
    output logic [31:0]                       tlb_lu_vaddr_o,
    input  logic                              tlb_lu_hit_i,
    input  logic                              tlb_lu_is_4M_i,
    input  logic [31:0]                       tlb_lu_content_i
`ifdef TLB_ARB_PERF_CNT_EN
    ,
    output logic [31:0]                       perf_hit_cnt_o,
    output logic [31:0]                       perf_miss_cnt_o
`endif
);

    localparam int RR_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_QUIESCE
    } state_e;

    state_e                 state_q, state_d;
    logic [RR_W-1:0]        rr_q, rr_d;
    logic [SC_W-1:0]        starve_q, starve_d;
    logic [NUM_CLIENTS-1:0] rsp_valid_q;
    logic                   rsp_hit_q;
    logic                   rsp_is_4M_q;
    logic [31:0]            rsp_content_q;

    logic [8:0]             upd_asid_ext;
    logic                   lu_pending;
    logic                   starve_hold;
    logic                   found;
    int                     gnt_idx;

    assign lu_pending  = |lu_req_i;
    // Once updates have won STARVE_LIMIT times in a row, a pending lookup gets the next slot.
    assign starve_hold = (starve_q == STARVE_MAX) && lu_pending;

    always_comb begin
        found   = 1'b0;
        gnt_idx = 0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (!found && lu_req_i[(int'(rr_q) + k) % NUM_CLIENTS]) begin
                found   = 1'b1;
                gnt_idx = (int'(rr_q) + k) % NUM_CLIENTS;
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        rr_d              = rr_q;
        starve_d          = starve_q;
        flush_ack_o       = 1'b0;
        tlb_flush_o       = 1'b0;
        tlb_flush_asid_o  = '0;
        tlb_flush_vaddr_o = '0;
        upd_ready_o       = 1'b0;
        tlb_update_o      = '0;
        lu_gnt_o          = '0;
        tlb_lu_access_o   = 1'b0;
        tlb_lu_asid_o     = '0;
        tlb_lu_vaddr_o    = '0;
        upd_asid_ext      = '0;
        upd_asid_ext[ASID_WIDTH-1:0] = upd_asid_i;

        // Reset forces every combinational output low so a grant in that cycle is never issued.
        if (rst_ni) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (flush_req_i) begin
                        state_d = ST_FLUSH;
                    end else if (upd_valid_i && !starve_hold) begin
                        upd_ready_o  = 1'b1;
                        tlb_update_o = {1'b1, upd_is_4M_i, upd_vpn_i, upd_asid_ext, upd_content_i};
                    end else if (found) begin
                        lu_gnt_o[gnt_idx] = 1'b1;
                        tlb_lu_access_o   = 1'b1;
                        tlb_lu_vaddr_o    = lu_vaddr_i[32*gnt_idx +: 32];
                        tlb_lu_asid_o     = lu_asid_i[ASID_WIDTH*gnt_idx +: ASID_WIDTH];
                        rr_d              = RR_W'((gnt_idx + 1) % NUM_CLIENTS);
                    end
                end
                ST_FLUSH: begin
                    flush_ack_o       = 1'b1;
                    tlb_flush_o       = 1'b1;
                    tlb_flush_asid_o  = flush_asid_i;
                    tlb_flush_vaddr_o = flush_vaddr_i;
                    state_d           = ST_QUIESCE;
                end
                ST_QUIESCE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (!lu_pending || tlb_lu_access_o) begin
                starve_d = '0;
            end else if (upd_ready_o && (starve_q != STARVE_MAX)) begin
                starve_d = starve_q + SC_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            rr_q          <= '0;
            starve_q      <= '0;
            rsp_valid_q   <= '0;
            rsp_hit_q     <= 1'b0;
            rsp_is_4M_q   <= 1'b0;
            rsp_content_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            starve_q    <= starve_d;
            rsp_valid_q <= lu_gnt_o;
            if (tlb_lu_access_o) begin
                rsp_hit_q     <= tlb_lu_hit_i;
                rsp_is_4M_q   <= tlb_lu_is_4M_i;
                rsp_content_q <= tlb_lu_content_i;
            end
        end
    end

    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_hit_o     = rsp_hit_q;
    assign rsp_is_4M_o   = rsp_is_4M_q;
    assign rsp_content_o = rsp_content_q;

`ifdef TLB_ARB_PERF_CNT_EN
    logic [31:0] perf_hit_q, perf_miss_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            perf_hit_q  <= '0;
            perf_miss_q <= '0;
        end else if (|rsp_valid_q) begin
            if (rsp_hit_q && (perf_hit_q != 32'hFFFF_FFFF)) begin
                perf_hit_q <= perf_hit_q + 32'd1;
            end else if (!rsp_hit_q && (perf_miss_q != 32'hFFFF_FFFF)) begin
                perf_miss_q <= perf_miss_q + 32'd1;
            end
        end
    end

    assign perf_hit_cnt_o  = perf_hit_q;
    assign perf_miss_cnt_o = perf_miss_q;
`endif

endmodule

// File: tb/tb_tlb_access_arbiter_sv32.sv
// tb/tb_tlb_access_arbiter_sv32.sv - scoreboard bench for tlb_access_arbiter_sv32 with a behavioural TLB stand-in
module tb_tlb_access_arbiter_sv32;

    localparam int NC = 2;
    localparam int AW = 1;
    localparam int SL = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              flush_req;
    logic [AW-1:0]     flush_asid;
    logic [31:0]       flush_vaddr;
    logic              flush_ack;
    logic              upd_valid, upd_ready, upd_4m;
    logic [19:0]       upd_vpn;
    logic [AW-1:0]     upd_asid;
    logic [31:0]       upd_content;
    logic [NC-1:0]     lu_req, lu_gnt, rsp_valid;
    logic [NC*32-1:0]  lu_vaddr;
    logic [NC*AW-1:0]  lu_asid;
    logic              rsp_hit, rsp_4m;
    logic [31:0]       rsp_content;
    logic              tlb_flush;
    logic [AW-1:0]     tlb_flush_asid;
    logic [31:0]       tlb_flush_vaddr;
    logic [62:0]       tlb_update;
    logic              tlb_lu_access;
    logic [AW-1:0]     tlb_lu_asid;
    logic [31:0]       tlb_lu_vaddr;
    logic              tlb_lu_hit, tlb_lu_4m;
    logic [31:0]       tlb_lu_content;
`ifdef TLB_ARB_PERF_CNT_EN
    logic [31:0]       perf_hit, perf_miss;
`endif

    tlb_access_arbiter_sv32 #(.NUM_CLIENTS(NC), .ASID_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .flush_req_i(flush_req), .flush_asid_i(flush_asid), .flush_vaddr_i(flush_vaddr), .flush_ack_o(flush_ack),
        .upd_valid_i(upd_valid), .upd_ready_o(upd_ready), .upd_vpn_i(upd_vpn), .upd_asid_i(upd_asid),
        .upd_is_4M_i(upd_4m), .upd_content_i(upd_content),
        .lu_req_i(lu_req), .lu_vaddr_i(lu_vaddr), .lu_asid_i(lu_asid), .lu_gnt_o(lu_gnt),
        .rsp_valid_o(rsp_valid), .rsp_hit_o(rsp_hit), .rsp_is_4M_o(rsp_4m), .rsp_content_o(rsp_content),
        .tlb_flush_o(tlb_flush), .tlb_flush_asid_o(tlb_flush_asid), .tlb_flush_vaddr_o(tlb_flush_vaddr),
        .tlb_update_o(tlb_update), .tlb_lu_access_o(tlb_lu_access), .tlb_lu_asid_o(tlb_lu_asid),
        .tlb_lu_vaddr_o(tlb_lu_vaddr), .tlb_lu_hit_i(tlb_lu_hit), .tlb_lu_is_4M_i(tlb_lu_4m),
        .tlb_lu_content_i(tlb_lu_content)
`ifdef TLB_ARB_PERF_CNT_EN
        , .perf_hit_cnt_o(perf_hit), .perf_miss_cnt_o(perf_miss)
`endif
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit ent_match(logic [19:0] vpn, bit is4m, logic [AW-1:0] easid,
                                     logic [31:0] va, logic [AW-1:0] asid);
        if (easid != asid) return 1'b0;
        if (is4m) return vpn[19:10] == va[31:22];
        return vpn == va[31:12];
    endfunction

    function automatic bit flush_match(logic [19:0] vpn, logic [AW-1:0] easid,
                                       logic [31:0] fva, logic [AW-1:0] fasid);
        return (fva == 32'd0 || vpn == fva[31:12]) && (fasid == '0 || easid == fasid);
    endfunction

    // TLB stand-in driven only by the DUT's TLB-side ports
    bit [7:0]      f_v;
    logic [19:0]   f_vpn[8];
    logic [AW-1:0] f_asid[8];
    bit            f_4m[8];
    logic [31:0]   f_con[8];
    int            f_wp = 0;

    always @(posedge clk) begin
        if (tlb_flush)
            for (int i = 0; i < 8; i++)
                if (flush_match(f_vpn[i], f_asid[i], tlb_flush_vaddr, tlb_flush_asid)) f_v[i] <= 1'b0;
        if (tlb_update[62]) begin
            f_v[f_wp]    <= 1'b1;
            f_4m[f_wp]   <= tlb_update[61];
            f_vpn[f_wp]  <= tlb_update[60:41];
            f_asid[f_wp] <= tlb_update[32 +: AW];
            f_con[f_wp]  <= tlb_update[31:0];
            f_wp         <= (f_wp + 1) % 8;
        end
    end

    always_comb begin
        tlb_lu_hit = 1'b0; tlb_lu_4m = 1'b0; tlb_lu_content = '0;
        for (int i = 0; i < 8; i++)
            if (!tlb_lu_hit && f_v[i] && ent_match(f_vpn[i], f_4m[i], f_asid[i], tlb_lu_vaddr, tlb_lu_asid)) begin
                tlb_lu_hit = 1'b1; tlb_lu_4m = f_4m[i]; tlb_lu_content = f_con[i];
            end
    end

    // Reference model state: its own copy of the translation table fed from predicted updates
    bit [7:0]      m_v;
    logic [19:0]   m_vpn[8];
    logic [AW-1:0] m_asid[8];
    bit            m_4m[8];
    logic [31:0]   m_con[8];
    int m_wp = 0, m_mode = 0, m_rr = 0, m_starve = 0, m_hits = 0, m_miss = 0;
    bit flush_done = 0;

    typedef struct { int client; bit hit; logic [31:0] content; int due; } rsp_t;
    rsp_t sb[$];

    logic [NC-1:0] s_gnt;
    logic          s_rdy, s_ack;
    logic [62:0]   s_upd;

    task automatic model_cycle();
        logic [NC-1:0] e_gnt = '0;
        bit            e_rdy = 0, e_fl = 0;
        logic [62:0]   e_upd = '0;
        logic [31:0]   e_va = '0;
        logic [AW-1:0] e_as = '0;
        int g = -1;
        int nxt;
        if (!rst_n) begin
            m_mode = 0; m_rr = 0; m_starve = 0; m_hits = 0; m_miss = 0;
        end else begin
            nxt = m_mode;
            if (m_mode == 1) begin
                e_fl = 1; nxt = 2;
                for (int i = 0; i < 8; i++)
                    if (flush_match(m_vpn[i], m_asid[i], flush_vaddr, flush_asid)) m_v[i] = 1'b0;
            end else if (m_mode == 2) begin
                nxt = 0;
            end else if (flush_req) begin
                nxt = 1;
            end else if (upd_valid && !(m_starve == SL && lu_req != 0)) begin
                e_rdy = 1;
                e_upd = {1'b1, upd_4m, upd_vpn, 9'(upd_asid), upd_content};
                m_v[m_wp] = 1; m_4m[m_wp] = upd_4m; m_vpn[m_wp] = upd_vpn;
                m_asid[m_wp] = upd_asid; m_con[m_wp] = upd_content;
                m_wp = (m_wp + 1) % 8;
            end else if (lu_req != 0) begin
                rsp_t r;
                for (int k = NC - 1; k >= 0; k--)
                    if (lu_req[(m_rr + k) % NC]) g = (m_rr + k) % NC;
                e_gnt[g] = 1'b1;
                e_va = lu_vaddr[32*g +: 32];
                e_as = lu_asid[AW*g +: AW];
                r.client = g; r.hit = 0; r.content = '0; r.due = cyc + 1;
                for (int i = 0; i < 8; i++)
                    if (!r.hit && m_v[i] && ent_match(m_vpn[i], m_4m[i], m_asid[i], e_va, e_as)) begin
                        r.hit = 1; r.content = m_con[i];
                    end
                if (r.hit) m_hits++; else m_miss++;
                sb.push_back(r);
                m_rr = (g + 1) % NC;
            end
            if (lu_req == 0 || g >= 0) m_starve = 0;
            else if (e_rdy && m_starve < SL) m_starve++;
            m_mode = nxt;
        end
        if (e_fl) flush_done = 1;
        s_gnt = lu_gnt; s_rdy = upd_ready; s_ack = flush_ack; s_upd = tlb_update;
        chk("lu_gnt", 128'(lu_gnt), 128'(e_gnt));
        chk("upd_ready", 128'(upd_ready), 128'(e_rdy));
        chk("tlb_update", 128'(tlb_update), 128'(e_upd));
        chk("flush_pulse", 128'({flush_ack, tlb_flush}), 128'({e_fl, e_fl}));
        chk("flush_data", 128'({tlb_flush_vaddr, tlb_flush_asid}),
            e_fl ? 128'({flush_vaddr, flush_asid}) : 128'(0));
        chk("lu_port", 128'({tlb_lu_access, tlb_lu_vaddr, tlb_lu_asid}), 128'({g >= 0, e_va, e_as}));
    endtask

    always @(posedge clk) begin
        #2;
        if (rsp_valid != '0) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 128'(rsp_valid), 128'(0));
            end else begin
                rsp_t e;
                e = sb.pop_front();
                chk("rsp_valid", 128'(rsp_valid), 128'(1 << e.client));
                chk("rsp_data", 128'({rsp_hit, rsp_content}), 128'({e.hit, e.content}));
                chk("rsp_timing", 128'(cyc), 128'(e.due));
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            chk("rsp_missing", 128'(rsp_valid), 128'(1 << sb[0].client));
            void'(sb.pop_front());
        end
    end

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] pick_vpn();
        logic [19:0] tbl[4] = '{20'h12345, 20'h00001, 20'h0ABCD, 20'h80000};
        return tbl[$urandom_range(0, 3)];
    endfunction

    logic [9:0]    rdy_bits;
    logic [NC-1:0] starve_gnt;

    initial begin
        rst_n = 0; flush_req = 0; flush_asid = '0; flush_vaddr = '0;
        upd_valid = 0; upd_vpn = '0; upd_asid = '0; upd_4m = 0; upd_content = '0;
        lu_req = '0; lu_vaddr = '0; lu_asid = '0;
        @(posedge clk); #1;
        lu_req = 2'b11;
        step(); step();
        chk("reset_rsp", 128'({rsp_valid, rsp_hit, rsp_4m, rsp_content}), 128'(0));

        rst_n = 1;
        lu_vaddr = {32'h0ABCD000, 32'h00001000};
        step(); chk("first_gnt", 128'(s_gnt), 128'(2'b01));
        step(); chk("second_gnt", 128'(s_gnt), 128'(2'b10));

        lu_req = '0; upd_valid = 1; upd_vpn = 20'h12345; upd_asid = 1'b1; upd_4m = 0; upd_content = 32'hDEADBEEF;
        step();
        chk("upd_vector", 128'(s_upd), 128'(63'h4246_8A01_DEAD_BEEF));
        upd_valid = 0; lu_req = 2'b01; lu_vaddr = {32'h0, 32'h12345000}; lu_asid = 2'b01;
        step();
        chk("hit_rsp", 128'({rsp_valid, rsp_hit, rsp_content}), 128'({2'b01, 1'b1, 32'hDEADBEEF}));

        flush_req = 1; flush_vaddr = 0; flush_asid = 0;
        upd_valid = 1; upd_vpn = 20'h00001; upd_asid = 0; upd_content = 32'h0000_0777;
        step(); chk("flush_idle_hold", 128'({s_gnt, s_rdy}), 128'(0));
        step(); chk("flush_ack", 128'(s_ack), 128'(1));
        flush_req = 0;
        step(); chk("quiesce_hold", 128'({s_gnt, s_rdy, s_ack}), 128'(0));
        step(); chk("upd_after_flush", 128'(s_rdy), 128'(1));
        upd_valid = 0;
        step();
        chk("miss_after_flush", 128'({rsp_valid, rsp_hit}), 128'({2'b01, 1'b0}));

        upd_valid = 1; lu_req = 2'b10; lu_vaddr = {32'h00001000, 32'h0};
        starve_gnt = '0;
        for (int i = 0; i < 10; i++) begin
            upd_content = $urandom;
            step();
            rdy_bits[i] = s_rdy;
            if (i == 4) starve_gnt = s_gnt;
        end
        chk("starve_pattern", 128'(rdy_bits), 128'(10'b0111101111));
        chk("starve_gnt", 128'(starve_gnt), 128'(2'b10));

        upd_valid = 0; lu_req = 2'b01;
        step();
        lu_req = 2'b11; rst_n = 0;
        step(); chk("reset_cycle_gnt", 128'(s_gnt), 128'(0));
        rst_n = 1; lu_req = '0;
        step(); chk("reset_drop_rsp", 128'({rsp_valid, rsp_content}), 128'(0));
        lu_req = 2'b11;
        step(); chk("rr_after_reset", 128'(s_gnt), 128'(2'b01));

        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            if (!flush_req && $urandom_range(0, 29) == 0) begin
                flush_req = 1;
                flush_vaddr = ($urandom_range(0, 2) == 0) ? 32'd0 : {pick_vpn(), 12'h000};
                flush_asid = AW'($urandom_range(0, 1));
            end
            upd_valid = ($urandom_range(0, 2) == 0);
            upd_vpn = pick_vpn(); upd_asid = AW'($urandom_range(0, 1));
            upd_4m = ($urandom_range(0, 7) == 0); upd_content = $urandom;
            lu_req = NC'($urandom_range(0, 3));
            lu_vaddr = {pick_vpn(), 12'(($urandom)), pick_vpn(), 12'(($urandom))};
            lu_asid = NC'($urandom_range(0, 3));
            flush_done = 0;
            step();
            if (flush_done) flush_req = 0;
        end

        rst_n = 1; flush_req = 0; upd_valid = 0; lu_req = '0;
        step(); step(); step();
        chk("sb_drain", 128'(sb.size()), 128'(0));
`ifdef TLB_ARB_PERF_CNT_EN
        chk("perf_hit", 128'(perf_hit), 128'(m_hits));
        chk("perf_miss", 128'(perf_miss), 128'(m_miss));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
